branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor with branch target buffer (BTB) for the 5-stage RISC-V pipeline.
- Replaces the fixed predict-not-taken policy, in which every taken branch or jump resolved in EX flushes IF/ID.
- The fetch stage looks up the current PC and gets a same-cycle predicted next PC.
- EX reports each resolved branch or jump. The block then updates its tables, flags mispredictions and supplies the redirect PC. It also keeps saturating performance counters.

---
 rtl/branch_predictor.sv | 200 ++++++++++++++++++++
 tb/tb_branch_predictor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor with a direct-mapped branch target buffer.
//
// The fetch side looks up if_pc and gets a same-cycle prediction
// (pred_taken / pred_pc). The execute side reports every resolved branch
// or jump. The block then flags a misprediction, supplies the correct next
// PC and trains its tables on the rising edge. Two saturating performance
// counters track resolved branches and mispredictions.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   if_pc             PC being fetched
//   pred_taken        predicted taken for if_pc
//   pred_pc           predicted next PC (target when taken, else if_pc+4)
//   upd_valid         a branch/jump resolves this cycle
//   upd_pc            PC of the resolving instruction
//   upd_is_jump       instruction is jal/jalr
//   upd_taken         actual direction
//   upd_target        actual target
//   upd_pred_taken    prediction carried with the instruction
//   upd_pred_pc       predicted next PC carried with the instruction
//   mispredict        flush request (same cycle as upd_valid)
//   redirect_pc       correct next PC; 0 when no update is active
//   perf_branches     saturating count of resolved branches
//   perf_mispredicts  saturating count of mispredictions
module branch_predictor #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_pc,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_pc,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - 2 - IDX_W;

    localparam logic [PC_W-1:0]   PC_STEP  = PC_W'(3'd4);
    localparam logic [CTR_W-1:0]  CTR_ONE  = CTR_W'(1'b1);
    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  CTR_WT   = CTR_ONE << (CTR_W - 1);
    localparam logic [CTR_W-1:0]  CTR_WNT  = CTR_WT - CTR_ONE;
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1'b1);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    // Saturating direction-counter increment.
    function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
        if (c == CTR_MAX) return c;
        else return c + CTR_ONE;
    endfunction

    // Saturating direction-counter decrement.
    function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
        if (c == '0) return c;
        else return c - CTR_ONE;
    endfunction

    // Saturating performance-counter increment (never wraps).
    function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] c);
        if (c == PERF_MAX) return c;
        else return c + PERF_ONE;
    endfunction

    logic             valid_r  [ENTRIES];
    logic [TAG_W-1:0] tag_r    [ENTRIES];
    logic [PC_W-1:0]  target_r [ENTRIES];
    logic             jump_r   [ENTRIES];
    logic [CTR_W-1:0] ctr_r    [ENTRIES];

    logic [PERF_W-1:0] perf_branches_r;
    logic [PERF_W-1:0] perf_mispredicts_r;

    logic [IDX_W-1:0] if_idx_s;
    logic [TAG_W-1:0] if_tag_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic [TAG_W-1:0] upd_tag_s;
    logic             if_hit_s;
    logic             upd_hit_s;
    logic             pred_taken_s;
    logic [PC_W-1:0]  pred_pc_s;
    logic             upd_active_s;
    logic [PC_W-1:0]  actual_next_s;
    logic             mispredict_s;
    logic [PC_W-1:0]  redirect_pc_s;

    // Direction is already encoded in upd_pred_pc; the flag is carried only
    // for pipeline visibility and does not affect the comparison.
    logic unused_pred_taken_s;
    assign unused_pred_taken_s = upd_pred_taken;

    assign if_idx_s  = if_pc[IDX_W+1:2];
    assign if_tag_s  = if_pc[PC_W-1:IDX_W+2];
    assign upd_idx_s = upd_pc[IDX_W+1:2];
    assign upd_tag_s = upd_pc[PC_W-1:IDX_W+2];
    assign upd_active_s = upd_valid & ~reset;

    // Fetch-side lookup: reads the flops directly, so a same-cycle update
    // becomes visible only from the next cycle.
    always_comb begin
        if_hit_s     = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
        pred_taken_s = 1'b0;
        pred_pc_s    = if_pc + PC_STEP;
        if (reset) begin
            pred_taken_s = 1'b0;
        end else begin
            pred_taken_s = if_hit_s && (jump_r[if_idx_s] || ctr_r[if_idx_s][CTR_W-1]);
        end
        if (pred_taken_s) begin
            pred_pc_s = target_r[if_idx_s];
        end else begin
            pred_pc_s = if_pc + PC_STEP;
        end
    end

    // Resolution: compare the true next PC with what fetch followed.
    always_comb begin
        upd_hit_s     = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
        actual_next_s = upd_pc + PC_STEP;
        mispredict_s  = 1'b0;
        redirect_pc_s = '0;
        if (upd_taken) begin
            actual_next_s = upd_target;
        end else begin
            actual_next_s = upd_pc + PC_STEP;
        end
        if (upd_active_s) begin
            mispredict_s  = (actual_next_s != upd_pred_pc);
            redirect_pc_s = actual_next_s;
        end else begin
            mispredict_s  = 1'b0;
            redirect_pc_s = '0;
        end
    end

    // Table training: hits adjust the counter, taken misses allocate.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= '0;
                jump_r[i]   <= 1'b0;
                ctr_r[i]    <= CTR_WNT;
            end
        end else if (upd_valid) begin
            if (upd_hit_s) begin
                if (upd_taken) begin
                    ctr_r[upd_idx_s]    <= ctr_inc(ctr_r[upd_idx_s]);
                    target_r[upd_idx_s] <= upd_target;
                    jump_r[upd_idx_s]   <= upd_is_jump;
                end else begin
                    ctr_r[upd_idx_s] <= ctr_dec(ctr_r[upd_idx_s]);
                end
            end else if (upd_taken) begin
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= upd_tag_s;
                target_r[upd_idx_s] <= upd_target;
                jump_r[upd_idx_s]   <= upd_is_jump;
                ctr_r[upd_idx_s]    <= CTR_WT;
            end
        end
    end

    // Performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_branches_r    <= '0;
            perf_mispredicts_r <= '0;
        end else begin
            if (upd_valid) begin
                perf_branches_r <= perf_inc(perf_branches_r);
            end
            if (mispredict_s) begin
                perf_mispredicts_r <= perf_inc(perf_mispredicts_r);
            end
        end
    end

    assign pred_taken       = pred_taken_s;
    assign pred_pc          = pred_pc_s;
    assign mispredict       = mispredict_s;
    assign redirect_pc      = redirect_pc_s;
    assign perf_branches    = perf_branches_r;
    assign perf_mispredicts = perf_mispredicts_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default parameters:
// PC_W=9, ENTRIES=16, CTR_W=2, PERF_W=16). Index = pc[5:2], tag = pc[8:6],
// so 0x040, 0x080 and 0x0C0 all share index 0 with tags 1, 2 and 3.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [8:0]  if_pc;
    logic        pred_taken;
    logic [8:0]  pred_pc;
    logic        upd_valid;
    logic [8:0]  upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [8:0]  upd_target;
    logic        upd_pred_taken;
    logic [8:0]  upd_pred_pc;
    logic        mispredict;
    logic [8:0]  redirect_pc;
    logic [15:0] perf_branches;
    logic [15:0] perf_mispredicts;

    int chk_cnt = 0;
    int err_cnt = 0;
    int exp_br  = 0;
    int exp_mis = 0;

    branch_predictor #(
        .PC_W(9), .ENTRIES(16), .CTR_W(2), .PERF_W(16)
    ) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_pc(pred_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [8:0] pc, input logic exp_t, input logic [8:0] exp_pc);
        if_pc = pc;
        #1;
        check_val({tag, "_taken"}, 32'(pred_taken), 32'(exp_t));
        check_val({tag, "_pc"}, 32'(pred_pc), 32'(exp_pc));
    endtask

    task automatic check_perf(input string tag);
        check_val({tag, "_br"}, 32'(perf_branches), 32'(exp_br));
        check_val({tag, "_mis"}, 32'(perf_mispredicts), 32'(exp_mis));
    endtask

    // One resolved update: check same-cycle flush, then clock it in.
    task automatic upd(input string tag, input logic [8:0] pc, input logic jmp, input logic tkn,
                       input logic [8:0] tgt, input logic [8:0] ppc,
                       input logic exp_mp, input logic [8:0] exp_rd);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_is_jump    = jmp;
        upd_taken      = tkn;
        upd_target     = tgt;
        upd_pred_pc    = ppc;
        upd_pred_taken = (ppc != (pc + 9'd4));
        #1;
        check_val({tag, "_mp"}, 32'(mispredict), 32'(exp_mp));
        if (exp_mp) check_val({tag, "_rd"}, 32'(redirect_pc), 32'(exp_rd));
        @(posedge clk);
        exp_br++;
        if (exp_mp) exp_mis++;
        #1;
        upd_valid = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        if_pc = 9'h040;
        // Update presented while reset is high: must be ignored.
        upd_valid = 1'b1; upd_pc = 9'h040; upd_is_jump = 1'b0; upd_taken = 1'b1;
        upd_target = 9'h010; upd_pred_taken = 1'b0; upd_pred_pc = 9'h044;
        #1;
        check_val("rst_mp", 32'(mispredict), 32'h0);
        check_val("rst_rd", 32'(redirect_pc), 32'h0);
        check_val("rst_pt", 32'(pred_taken), 32'h0);
        check_val("rst_pp", 32'(pred_pc), 32'h044);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        upd_valid = 1'b0;
        check_perf("rst");
        look("rst_lk", 9'h040, 1'b0, 9'h044);

        // First taken update allocates; lookup in the same cycle sees old state.
        if_pc = 9'h040;
        upd_valid = 1'b1; upd_pc = 9'h040; upd_is_jump = 1'b0; upd_taken = 1'b1;
        upd_target = 9'h010; upd_pred_taken = 1'b0; upd_pred_pc = 9'h044;
        #1;
        check_val("alloc_mp", 32'(mispredict), 32'h1);
        check_val("alloc_rd", 32'(redirect_pc), 32'h010);
        check_val("alloc_same_pt", 32'(pred_taken), 32'h0);
        check_val("alloc_same_pp", 32'(pred_pc), 32'h044);
        @(posedge clk);
        exp_br++;
        exp_mis++;
        #1;
        upd_valid = 1'b0;
        look("alloc_lk", 9'h040, 1'b1, 9'h010);
        check_perf("alloc");

        // ctr 2 -> 3 -> 3 (saturate high)
        upd("t2", 9'h040, 1'b0, 1'b1, 9'h010, 9'h010, 1'b0, 9'h010);
        upd("t3", 9'h040, 1'b0, 1'b1, 9'h010, 9'h010, 1'b0, 9'h010);
        look("sat_hi_lk", 9'h040, 1'b1, 9'h010);

        // ctr 3 -> 2 -> 1 -> 0 -> 0; predictions taken, taken, not, not
        upd("nt1", 9'h040, 1'b0, 1'b0, 9'h010, 9'h010, 1'b1, 9'h044);
        look("nt1_lk", 9'h040, 1'b1, 9'h010);
        upd("nt2", 9'h040, 1'b0, 1'b0, 9'h010, 9'h010, 1'b1, 9'h044);
        look("nt2_lk", 9'h040, 1'b0, 9'h044);
        upd("nt3", 9'h040, 1'b0, 1'b0, 9'h010, 9'h044, 1'b0, 9'h044);
        look("nt3_lk", 9'h040, 1'b0, 9'h044);
        upd("nt4", 9'h040, 1'b0, 1'b0, 9'h010, 9'h044, 1'b0, 9'h044);
        look("sat_lo_lk", 9'h040, 1'b0, 9'h044);
        check_perf("nt");

        // jal at 0x080 evicts 0x040; the jump bit keeps it taken as ctr drops.
        upd("jal", 9'h080, 1'b1, 1'b1, 9'h100, 9'h084, 1'b1, 9'h100);
        look("jal_lk", 9'h080, 1'b1, 9'h100);
        look("jal_evict", 9'h040, 1'b0, 9'h044);
        upd("jnt1", 9'h080, 1'b0, 1'b0, 9'h100, 9'h100, 1'b1, 9'h084);
        look("jnt1_lk", 9'h080, 1'b1, 9'h100);
        upd("jnt2", 9'h080, 1'b0, 1'b0, 9'h100, 9'h100, 1'b1, 9'h084);
        look("jnt2_lk", 9'h080, 1'b1, 9'h100);

        // Aliasing on index 0: 0x040 re-allocated, then replaced by 0x0C0.
        upd("re040", 9'h040, 1'b0, 1'b1, 9'h010, 9'h044, 1'b1, 9'h010);
        look("re040_lk", 9'h040, 1'b1, 9'h010);
        look("re040_080", 9'h080, 1'b0, 9'h084);
        upd("a0c0", 9'h0C0, 1'b0, 1'b1, 9'h020, 9'h0C4, 1'b1, 9'h020);
        look("alias_040", 9'h040, 1'b0, 9'h044);
        look("alias_0c0", 9'h0C0, 1'b1, 9'h020);
        check_perf("alias");

        // Fall-through PC wraps at the top of the address space.
        look("wrap", 9'h1FC, 1'b0, 9'h000);

        // No update active: flush low and redirect driven to zero.
        upd_valid = 1'b0;
        upd_taken = 1'b1;
        upd_target = 9'h155;
        #1;
        check_val("idle_mp", 32'(mispredict), 32'h0);
        check_val("idle_rd", 32'(redirect_pc), 32'h0);

        // Mid-stream reset drops all learned state and counters.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_br = 0;
        exp_mis = 0;
        look("mid_rst", 9'h0C0, 1'b0, 9'h0C4);
        check_perf("mid_rst");

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
